alu_muldiv_unit: RTL

- Parametrised next-generation execute-stage ALU for the pipelined MIPS core.
- Logic, arithmetic, compare and shift ops are registered, with a one-cycle latency.
- Adds an iterative multiply/divide engine that writes HI/LO registers and back-pressures the pipeline through a ready/busy handshake.
- Sits between the ID/EX pipeline register and the EX/MEM register. The hazard unit consumes in_ready as its stall signal.

---
 rtl/alu_muldiv_unit.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_muldiv_unit.sv
// Execute-stage ALU with a registered single-cycle datapath and an
// iterative multiply/divide engine that owns the HI/LO registers.
module alu_muldiv_unit #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             out_valid,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             md_done,
  output logic             div_by_zero
);

  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t r_state;
  state_t w_state_next;

  // Single-cycle datapath registers
  logic [WIDTH-1:0] r_result;
  logic             r_overflow;
  logic             r_out_valid;

  // Mul/div engine registers
  logic [WIDTH-1:0] r_work_hi;   // partial product upper half / partial remainder
  logic [WIDTH-1:0] r_work_lo;   // multiplier / dividend-quotient shift register
  logic [WIDTH-1:0] r_opnd;      // multiplicand / divisor magnitude
  logic [SHW-1:0]   r_cnt;
  logic             r_is_div;
  logic             r_neg_q;     // product or quotient must be negated
  logic             r_neg_r;     // remainder takes the dividend's sign
  logic             r_dbz;       // divisor was zero
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_md_done;
  logic             r_div_by_zero;

  logic w_accept;
  logic w_is_md;
  logic w_accept_alu;
  logic w_accept_md;
  logic w_last;

  assign w_accept     = in_valid && in_ready;
  assign w_is_md      = alu_control[3] & alu_control[2];
  assign w_accept_alu = w_accept & ~w_is_md;
  assign w_accept_md  = w_accept & w_is_md;
  assign w_last       = (r_state == S_BUSY) && (r_cnt == SHW'(WIDTH - 1));

  assign in_ready    = (r_state == S_IDLE);
  assign result      = r_result;
  assign zero        = (r_result == '0);
  assign overflow    = r_overflow;
  assign out_valid   = r_out_valid;
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign md_done     = r_md_done;
  assign div_by_zero = r_div_by_zero;

  // ---------------------------------------------------------------
  // Single-cycle ALU
  // ---------------------------------------------------------------
  logic [WIDTH-1:0] w_add;
  logic [WIDTH-1:0] w_sub;
  logic [WIDTH-1:0] w_sra;
  logic             w_ovf_add;
  logic             w_ovf_sub;
  logic [WIDTH-1:0] w_alu_result;

  assign w_add     = a + b;
  assign w_sub     = a - b;
  assign w_sra     = $signed(b) >>> shamt;
  assign w_ovf_add = (a[WIDTH-1] == b[WIDTH-1]) && (w_add[WIDTH-1] != a[WIDTH-1]);
  assign w_ovf_sub = (a[WIDTH-1] != b[WIDTH-1]) && (w_sub[WIDTH-1] != a[WIDTH-1]);

  // Operation select for the single-cycle ops
  always_comb begin
    w_alu_result = '0;
    case (alu_control)
      4'b0000: w_alu_result = a & b;
      4'b0001: w_alu_result = a | b;
      4'b0010: w_alu_result = w_add;
      4'b0011: w_alu_result = a ^ b;
      4'b0100: w_alu_result = ~(a | b);
      4'b0101: w_alu_result = b;
      4'b0110: w_alu_result = w_sub;
      4'b0111: w_alu_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      4'b1000: w_alu_result = {{(WIDTH-1){1'b0}}, (a < b)};
      4'b1001: w_alu_result = b << shamt;
      4'b1010: w_alu_result = b >> shamt;
      4'b1011: w_alu_result = w_sra;
      default: w_alu_result = '0;
    endcase
  end

  // Register the ALU result; overflow only tracks ADD/SUB
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result    <= '0;
      r_overflow  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= w_accept_alu;
      if (w_accept_alu) begin
        r_result <= w_alu_result;
        if (alu_control == OP_ADD) begin
          r_overflow <= w_ovf_add;
        end else if (alu_control == OP_SUB) begin
          r_overflow <= w_ovf_sub;
        end
      end
    end
  end

  // ---------------------------------------------------------------
  // Mul/div engine
  // ---------------------------------------------------------------
  logic             w_md_signed;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;

  assign w_md_signed = ~alu_control[0];
  assign w_a_mag     = (w_md_signed && a[WIDTH-1]) ? -a : a;
  assign w_b_mag     = (w_md_signed && b[WIDTH-1]) ? -b : b;

  // One shift-add multiply step: add multiplicand when LSB set, shift right
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH-1:0] w_mul_hi;
  logic [WIDTH-1:0] w_mul_lo;

  assign w_mul_sum = {1'b0, r_work_hi} + (r_work_lo[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_hi  = w_mul_sum[WIDTH:1];
  assign w_mul_lo  = {w_mul_sum[0], r_work_lo[WIDTH-1:1]};

  // One restoring divide step: shift in next dividend bit, subtract if it fits
  logic [WIDTH:0]   w_div_shift;
  logic             w_div_ge;
  logic [WIDTH-1:0] w_div_hi;
  logic [WIDTH-1:0] w_div_lo;

  assign w_div_shift = {r_work_hi, r_work_lo[WIDTH-1]};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
  assign w_div_hi    = w_div_ge ? (w_div_shift[WIDTH-1:0] - r_opnd) : w_div_shift[WIDTH-1:0];
  assign w_div_lo    = {r_work_lo[WIDTH-2:0], w_div_ge};

  logic [WIDTH-1:0]   w_step_hi;
  logic [WIDTH-1:0]   w_step_lo;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;

  assign w_step_hi  = r_is_div ? w_div_hi : w_mul_hi;
  assign w_step_lo  = r_is_div ? w_div_lo : w_mul_lo;
  assign w_prod     = {w_step_hi, w_step_lo};
  assign w_prod_fix = r_neg_q ? -w_prod : w_prod;

  // Sign correction of the final step; a zero divisor forces an all-ones quotient
  logic [WIDTH-1:0] w_fin_hi;
  logic [WIDTH-1:0] w_fin_lo;

  always_comb begin
    w_fin_hi = w_prod_fix[2*WIDTH-1:WIDTH];
    w_fin_lo = w_prod_fix[WIDTH-1:0];
    if (r_is_div) begin
      w_fin_hi = r_neg_r ? -w_step_hi : w_step_hi;
      if (r_dbz) begin
        w_fin_lo = '1;
      end else begin
        w_fin_lo = r_neg_q ? -w_step_lo : w_step_lo;
      end
    end
  end

  // Busy/idle state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: leave idle on a mul/div accept, return after the last iteration
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept_md) w_state_next = S_BUSY;
      S_BUSY:  if (w_last)      w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Latch operands on accept, iterate while busy, commit HI/LO on the last step
  always_ff @(posedge clk) begin
    if (rst) begin
      r_work_hi     <= '0;
      r_work_lo     <= '0;
      r_opnd        <= '0;
      r_cnt         <= '0;
      r_is_div      <= 1'b0;
      r_neg_q       <= 1'b0;
      r_neg_r       <= 1'b0;
      r_dbz         <= 1'b0;
      r_hi          <= '0;
      r_lo          <= '0;
      r_md_done     <= 1'b0;
      r_div_by_zero <= 1'b0;
    end else begin
      r_md_done <= 1'b0;
      if (w_accept_md) begin
        r_work_hi     <= '0;
        r_work_lo     <= w_a_mag;
        r_opnd        <= w_b_mag;
        r_cnt         <= '0;
        r_is_div      <= alu_control[1];
        r_neg_q       <= w_md_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
        r_neg_r       <= w_md_signed & a[WIDTH-1];
        r_dbz         <= alu_control[1] & (b == '0);
        r_div_by_zero <= 1'b0;
      end else if (r_state == S_BUSY) begin
        r_work_hi <= w_step_hi;
        r_work_lo <= w_step_lo;
        r_cnt     <= r_cnt + SHW'(1);
        if (w_last) begin
          r_hi          <= w_fin_hi;
          r_lo          <= w_fin_lo;
          r_md_done     <= 1'b1;
          r_div_by_zero <= r_dbz;
        end
      end
    end
  end

endmodule
